// File: rtl/polar_pkg.sv
`default_nettype none
// polar_pkg: shared constants, FSM state type and helpers for the polar partial-sum generator.
package polar_pkg;

  localparam int POLAR_N_LOG = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } psum_state_t;

  // Number of consecutive ones starting at bit 0 of idx, capped at width.
  function automatic int trailing_ones(input int unsigned idx, input int width);
    int n;
    n = 0;
    for (int b = 0; b < width; b++) begin
      if (idx[b] && (n == b)) n++;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_combine.sv
`default_nettype none
// psum_combine: one polar butterfly level, returns {v, L ^ v} (upper half v, lower half L ^ v).
module psum_combine #(
  parameter int W = 1
) (
  input  logic [W-1:0]   l_i,
  input  logic [W-1:0]   v_i,
  output logic [2*W-1:0] comb_o
);

  assign comb_o = {v_i, l_i ^ v_i};

endmodule
`default_nettype wire

// File: rtl/polar_psum_gen.sv
`default_nettype none
// polar_psum_gen: SC polar decoder partial-sum generator, serves us vectors per tree level.
// Optional macro PSUM_CODEWORD_OUT_EN adds cw_out/cw_valid carrying the full re-encoded frame.
module polar_psum_gen
  import polar_pkg::*;
#(
  parameter int N_LOG = POLAR_N_LOG,
  parameter int N     = 2**N_LOG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  input  logic             us_req_valid,
  input  logic [N_LOG-1:0] us_req_level,
  output logic             us_req_ready,
  output logic [N/2-1:0]   us_out,
  output logic             us_out_valid,
  output logic [N_LOG-1:0] bit_idx,
  output logic             frame_done
`ifdef PSUM_CODEWORD_OUT_EN
  ,
  output logic [N-1:0]     cw_out,
  output logic             cw_valid
`endif
);

  localparam int HALF = N / 2;
  localparam int LW   = $clog2(N_LOG + 1);
`ifdef PSUM_CODEWORD_OUT_EN
  localparam int VW    = N;
  localparam int NCOMB = N_LOG;
`else
  // Without the codeword port the last-level combine result is never consumed.
  localparam int VW    = HALF;
  localparam int NCOMB = N_LOG - 1;
`endif

  psum_state_t      state_q, state_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [N_LOG-1:0] idx_q, idx_d;
  logic [VW-1:0]    v_q, v_d;
  logic [HALF-1:0]  l_q [N_LOG];
  logic [HALF-1:0]  l_d [N_LOG];
  logic [HALF-1:0]  us_q, us_d;
  logic             us_valid_q, us_valid_d;
  logic             done_q, done_d;
  logic [VW-1:0]    comb [N_LOG];
`ifdef PSUM_CODEWORD_OUT_EN
  logic [N-1:0]     cw_q, cw_d;
  logic             cw_valid_q, cw_valid_d;
`endif

  for (genvar s = 0; s < N_LOG; s++) begin : g_level
    if (s < NCOMB) begin : g_comb
      localparam int W = 2**s;
      logic [2*W-1:0] comb_w;
      psum_combine #(.W(W)) u_combine (
        .l_i    (l_q[s][W-1:0]),
        .v_i    (v_q[W-1:0]),
        .comb_o (comb_w)
      );
      assign comb[s] = VW'(comb_w);
    end else begin : g_nocomb
      assign comb[s] = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    idx_d      = idx_q;
    v_d        = v_q;
    l_d        = l_q;
    us_d       = us_q;
    us_valid_d = 1'b0;
    done_d     = 1'b0;
`ifdef PSUM_CODEWORD_OUT_EN
    cw_d       = cw_q;
    cw_valid_d = 1'b0;
`endif
    if (frame_start) begin
      state_d = IDLE;
      lvl_d   = '0;
      idx_d   = '0;
      v_d     = '0;
      for (int s = 0; s < N_LOG; s++) l_d[s] = '0;
    end else if (state_q == IDLE) begin
      if (bit_valid) begin
        v_d     = VW'(bit_in);
        lvl_d   = '0;
        state_d = UPDATE;
      end
      // L is untouched in the accept cycle, so a concurrent request sees pre-update contents.
      if (us_req_valid) begin
        us_valid_d = 1'b1;
        us_d       = '0;
        for (int s = 0; s < N_LOG; s++) begin
          if (us_req_level == N_LOG'(s)) us_d = l_q[s];
        end
      end
    end else if (lvl_q == LW'(N_LOG)) begin
      done_d  = 1'b1;
      idx_d   = idx_q + N_LOG'(1);
      state_d = IDLE;
`ifdef PSUM_CODEWORD_OUT_EN
      cw_d       = v_q;
      cw_valid_d = 1'b1;
`endif
    end else begin
      for (int s = 0; s < N_LOG; s++) begin
        if (lvl_q == LW'(s)) begin
          if (idx_q[s]) begin
            v_d   = comb[s];
            lvl_d = lvl_q + LW'(1);
          end else begin
            l_d[s]  = HALF'(v_q);
            idx_d   = idx_q + N_LOG'(1);
            state_d = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lvl_q      <= '0;
      idx_q      <= '0;
      v_q        <= '0;
      for (int s = 0; s < N_LOG; s++) l_q[s] <= '0;
      us_q       <= '0;
      us_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef PSUM_CODEWORD_OUT_EN
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      idx_q      <= idx_d;
      v_q        <= v_d;
      l_q        <= l_d;
      us_q       <= us_d;
      us_valid_q <= us_valid_d;
      done_q     <= done_d;
`ifdef PSUM_CODEWORD_OUT_EN
      cw_q       <= cw_d;
      cw_valid_q <= cw_valid_d;
`endif
    end
  end

  assign bit_ready    = (state_q == IDLE);
  assign us_req_ready = (state_q == IDLE);
  assign us_out       = us_q;
  assign us_out_valid = us_valid_q;
  assign bit_idx      = idx_q;
  assign frame_done   = done_q;
`ifdef PSUM_CODEWORD_OUT_EN
  assign cw_out       = cw_q;
  assign cw_valid     = cw_valid_q;
`endif

endmodule
`default_nettype wire
